// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one 32-bit adder/subtractor among NREQ requesters,
// with a single registered result slot. Optional rsp_ovf output: define ADDSUB_ARBITER_OVF_EN.
module addsub_arbiter #(
   parameter int unsigned NREQ = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [32*NREQ-1:0]      req_a,
   input  logic [32*NREQ-1:0]      req_b,
   input  logic [NREQ-1:0]         req_sel,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [31:0]             rsp_data,
   output logic [$clog2(NREQ)-1:0] rsp_id
`ifdef ADDSUB_ARBITER_OVF_EN
   ,
   output logic                    rsp_ovf
`endif
);

   localparam int unsigned IDW = $clog2(NREQ);

   typedef enum logic {IDLE, RESP} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [IDW-1:0]  r_ptr;
   logic [IDW-1:0]  w_gnt_idx;
   logic [IDW-1:0]  w_ptr_nxt;
   logic            w_gnt_found;
   logic            w_can_accept;
   logic            w_xfer;
   logic [31:0]     w_a;
   logic [31:0]     w_b;
   logic            w_sel;
   logic [31:0]     w_res;
   logic [31:0]     r_data;
   logic [IDW-1:0]  r_id;

   // Round-robin search: first valid requester at or after r_ptr, wrapping.
   always_comb begin
      logic [IDW-1:0] w_idx;
      w_gnt_found = 1'b0;
      w_gnt_idx   = '0;
      w_idx       = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         w_idx = IDW'((32'(r_ptr) + k) % NREQ);
         if (!w_gnt_found && req_valid[w_idx]) begin
            w_gnt_found = 1'b1;
            w_gnt_idx   = w_idx;
         end
      end
   end

   assign w_ptr_nxt = (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + IDW'(1);

   assign w_a   = req_a[32*w_gnt_idx +: 32];
   assign w_b   = req_b[32*w_gnt_idx +: 32];
   assign w_sel = req_sel[w_gnt_idx];
   assign w_res = w_sel ? (w_a - w_b) : (w_a + w_b);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_xfer) w_state_nxt = RESP;
         RESP:    if (rsp_ready && !w_xfer) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // The slot can take a new result when empty or being drained this cycle.
   always_comb begin
      rsp_valid    = (r_state == RESP);
      w_can_accept = (r_state == IDLE) || rsp_ready;
      req_ready    = '0;
      if (!rst && w_gnt_found && w_can_accept) req_ready[w_gnt_idx] = 1'b1;
   end

   assign w_xfer = |req_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr  <= '0;
         r_data <= '0;
         r_id   <= '0;
      end else if (w_xfer) begin
         r_ptr  <= w_ptr_nxt;
         r_data <= w_res;
         r_id   <= w_gnt_idx;
      end
   end

   assign rsp_data = r_data;
   assign rsp_id   = r_id;

`ifdef ADDSUB_ARBITER_OVF_EN
   logic w_ovf;
   logic r_ovf;

   // Subtraction overflows when operand signs differ; addition when they match.
   assign w_ovf = ((w_a[31] ^ w_b[31]) == w_sel) && (w_res[31] != w_a[31]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if (w_xfer) begin
         r_ovf <= w_ovf;
      end
   end

   assign rsp_ovf = r_ovf;
`endif

endmodule
